// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame shape and bit-period math
// (the bit-period math is shared with the transmitter as well).
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and full/empty flags.
// A push is accepted while full only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_rx.sv
// 8N1 console receiver: two-flop synchronizer, mid-bit sampling FSM and a small
// receive FIFO so software polling gaps do not lose characters.
module uart_rx_fifo_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 26000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  logic [1:0]  sync;
  logic        rx_s;
  uart_state_e state;
  logic [CW-1:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic        push, pop, full, empty;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rxd};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (cnt == CNT_HALF) begin
          // A high line at mid-start is a glitch; drop it silently.
          cnt   <= '0;
          idx   <= '0;
          state <= rx_s ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == CNT_BIT) begin
          cnt <= '0;
          sh  <= {rx_s, sh[7:1]};
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == CNT_BIT) begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
          else begin
            frame_err <= 1'b1;
            state     <= WAIT_HIGH;
          end
        end else cnt <= cnt + 1'b1;
        // Hold off new starts until a break releases the line.
        WAIT_HIGH: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign push     = (state == STOP) && (cnt == CNT_BIT) && rx_s;
  assign rx_valid = !empty;
  assign pop      = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) overrun <= 1'b0;
    else       overrun <= push && full && !pop;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (sh),
    .pop       (pop),
    .pop_data  (rx_data),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo_rx.sv
// Bench for uart_rx_fifo_rx: host-side serial driver, popped-byte scoreboard and
// pulse counters, with vector table, random bytes and timed corner cases.
module tb_uart_rx_fifo_rx;
  localparam int BIT = 8680;   // host bit period, clock period is 38
  localparam int CPB = 226;

  logic       clk = 0, reset = 1, rxd = 1, rx_ready = 0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int tests = 0, fails = 0;
  int ferr_cnt = 0, ovr_cnt = 0;
  logic [7:0] popq[$];
  logic [7:0] expq[$];

  typedef struct {
    logic [7:0] data;
    bit         stop_low;
    int         exp_ferr;
    int         exp_recv;
  } vec_t;
  vec_t vecs[5];

  uart_rx_fifo_rx dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #19 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) popq.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
  end

  initial begin
    #12000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_obs();
    popq.delete();
    expq.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1 rx_ready = r;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_low, input int bt);
    rxd = 0; #(bt);
    for (int i = 0; i < 8; i++) begin rxd = d[i]; #(bt); end
    if (stop_low) begin rxd = 0; #(2 * bt); end
    rxd = 1; #(bt);
  endtask

  // Clock-aligned frame; optional single-cycle rx_ready pulse pop_at clocks after the start edge.
  task automatic send_cyc(input logic [7:0] d, input int pop_at);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 10; i++) begin rxd = f[i]; repeat (CPB) @(posedge clk); #1; end
      if (pop_at > 0) begin
        repeat (pop_at) @(posedge clk);
        #1 rx_ready = 1;
        @(posedge clk); #1 rx_ready = 0;
      end
    join
  endtask

  task automatic compare_q(input string name);
    logic [31:0] got;
    check({name, " count"}, popq.size(), expq.size());
    foreach (expq[i]) begin
      got = (i < popq.size()) ? {24'h0, popq[i]} : 32'hFFFF_FFFF;
      check($sformatf("%s byte%0d", name, i), got, {24'h0, expq[i]});
    end
  endtask

  initial begin
    vecs[0] = '{8'h2F, 1'b1, 1, 0};
    vecs[1] = '{8'h35, 1'b0, 0, 1};
    vecs[2] = '{8'h00, 1'b0, 0, 1};
    vecs[3] = '{8'hA5, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b0, 0, 1};

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset busy", busy, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    @(posedge clk); #1 reset = 0;
    set_ready(1);

    // Console stream
    clear_obs();
    expq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0A};
    foreach (expq[i]) send_byte(expq[i], 1'b0, BIT);
    #(2 * BIT);
    compare_q("stream");
    check("stream frame_err", ferr_cnt, 0);
    check("stream overrun", ovr_cnt, 0);

    // Vector table (framing errors interleaved with good bytes)
    foreach (vecs[v]) begin
      clear_obs();
      send_byte(vecs[v].data, vecs[v].stop_low, BIT);
      #(2 * BIT);
      check($sformatf("vec%0d frame_err", v), ferr_cnt, vecs[v].exp_ferr);
      check($sformatf("vec%0d pushed", v), popq.size(), vecs[v].exp_recv);
      if (vecs[v].exp_recv != 0 && popq.size() > 0)
        check($sformatf("vec%0d data", v), popq[0], vecs[v].data);
    end

    // Glitch: 40 clocks low must not start a frame
    clear_obs();
    @(posedge clk); #1 rxd = 0;
    repeat (40) @(posedge clk); #1 rxd = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("glitch busy mid", busy, 1);
    repeat (70) @(posedge clk);
    @(negedge clk);
    check("glitch busy end", busy, 0);
    #(BIT);
    check("glitch pushed", popq.size(), 0);
    check("glitch frame_err", ferr_cnt, 0);

    // Random bytes with host baud skew up to about 1.8%
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      expq.push_back(b);
      send_byte(b, 1'b0, $urandom_range(8620, 8740));
      #($urandom_range(0, 2 * BIT));
    end
    #(2 * BIT);
    compare_q("random");
    check("random frame_err", ferr_cnt, 0);

    // Overrun: fifth byte dropped
    set_ready(0);
    clear_obs();
    for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i), 1'b0, BIT);
    #(BIT);
    @(negedge clk);
    check("ovr pulses", ovr_cnt, 1);
    check("ovr rx_valid", rx_valid, 1);
    check("ovr head", rx_data, 8'h41);
    expq = '{8'h41, 8'h42, 8'h43, 8'h44};
    set_ready(1);
    repeat (8) @(posedge clk);
    #1 rx_ready = 0;
    @(negedge clk);
    check("ovr drained valid", rx_valid, 0);
    compare_q("ovr");

    // Full FIFO with pop on the exact stop-sample cycle
    clear_obs();
    for (int i = 0; i < 4; i++) send_byte(8'h41 + 8'(i), 1'b0, BIT);
    #(BIT);
    send_cyc(8'h46, CPB / 2 + 3 + 9 * CPB - 1);
    #(BIT);
    check("full pop overrun", ovr_cnt, 0);
    check("full pop popped", popq.size(), 1);
    @(negedge clk);
    check("full pop new head", rx_data, 8'h42);
    set_ready(1);
    repeat (8) @(posedge clk);
    expq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h46};
    compare_q("full pop");

    // Reset during data bits of 0x55, then 0x0D
    clear_obs();
    rxd = 0; #(BIT);
    for (int i = 0; i < 3; i++) begin rxd = 1'(8'h55 >> i); #(BIT); end
    #(BIT / 2);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0; rxd = 1;
    @(negedge clk);
    check("midreset busy", busy, 0);
    #(2 * BIT);
    send_byte(8'h0D, 1'b0, BIT);
    #(2 * BIT);
    expq = '{8'h0D};
    compare_q("midreset");
    check("midreset frame_err", ferr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
